// File: rtl/ddr_rd_port_arbiter_pkg.sv
// ddr_rd_port_arbiter_pkg: FSM state encoding and helper functions shared by the DDR read port arbiter
package ddr_rd_port_arbiter_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT_FIN = 2'd2} state_t;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) if ((1 << i) < n) r = i + 1;
    return r;
  endfunction
  function automatic logic [63:0] min_bytes(input logic [63:0] a, input logic [63:0] b);
    return a < b ? a : b;
  endfunction
  function automatic logic [63:0] rr_pick(input logic [63:0] req, input int ptr, input int n);
    logic [63:0] g;
    g = '0;
    for (int i = 0; i < 64; i++)
      if (i < n && g == '0 && req[(ptr + i) % n]) g[(ptr + i) % n] = 1'b1;
    return g;
  endfunction
endpackage

// File: rtl/ddr_rd_rr_arb.sv
// ddr_rd_rr_arb: combinational one-hot pick, round-robin from ptr (mode 0) or fixed priority from port 0 (mode 1)
module ddr_rd_rr_arb
  import ddr_rd_port_arbiter_pkg::*;
#(
  parameter int P_PORT_NUM = 4,
  parameter int P_ARB_MODE = 0,
  parameter int PW = clog2(P_PORT_NUM)
) (
  input  logic [P_PORT_NUM-1:0] req,
  input  logic [PW-1:0]         ptr,
  output logic [P_PORT_NUM-1:0] grant
);
  always_comb grant = P_PORT_NUM'(rr_pick(64'(req), P_ARB_MODE == 1 ? 0 : int'(ptr), P_PORT_NUM));
endmodule

// File: rtl/ddr_rd_port_arbiter.sv
// ddr_rd_port_arbiter: arbitrates per-port DDR read requests, splits each into bursts, pulses done and counts completions
module ddr_rd_port_arbiter
  import ddr_rd_port_arbiter_pkg::*;
#(
  parameter int P_PORT_NUM         = 4,
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int P_DDR_LOCAL_QUEUE  = 3,
  parameter int P_MAX_BURST_BYTE   = 4096,
  parameter int P_ARB_MODE         = 0,
  parameter int P_CNT_WIDTH        = 16
) (
  input  logic                                       i_clk,
  input  logic                                       i_rst_n,
  input  logic [P_PORT_NUM-1:0]                      i_req_valid,
  output logic [P_PORT_NUM-1:0]                      o_req_ready,
  input  logic [P_PORT_NUM*P_DDR_LOCAL_QUEUE-1:0]    i_req_queue,
  input  logic [P_PORT_NUM*C_M_AXI_ADDR_WIDTH-1:0]   i_req_byte,
  output logic                                       o_ddr_rd_valid,
  input  logic                                       i_ddr_rd_ready,
  output logic [P_DDR_LOCAL_QUEUE-1:0]               o_ddr_rd_queue,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]              o_ddr_rd_byte,
  output logic [clog2(P_PORT_NUM)-1:0]               o_ddr_rd_port,
  output logic                                       o_ddr_rd_last,
  input  logic                                       i_ddr_rd_finish,
  output logic [P_PORT_NUM-1:0]                      o_port_done,
  output logic [P_PORT_NUM-1:0]                      o_port_busy,
  output logic [P_PORT_NUM*P_CNT_WIDTH-1:0]          o_done_cnt
);
  localparam int N = P_PORT_NUM, AW = C_M_AXI_ADDR_WIDTH, Q = P_DDR_LOCAL_QUEUE, CW = P_CNT_WIDTH;
  localparam int PW = clog2(P_PORT_NUM);
  state_t state, state_nx;
  logic [PW-1:0] port, ptr, sel, fin_port;
  logic [Q-1:0] queue;
  logic [AW-1:0] rem, chunk, req_byte;
  logic [N-1:0] grant, done;
  logic [N*CW-1:0] cnt;
  logic acc, last, fin;
  ddr_rd_rr_arb #(.P_PORT_NUM(N), .P_ARB_MODE(P_ARB_MODE), .PW(PW)) u_arb (
    .req(i_req_valid), .ptr(ptr), .grant(grant)
  );
  always_comb begin
    sel = '0;
    for (int i = 0; i < N; i++) if (grant[i]) sel = PW'(i);
  end
  assign acc      = state == IDLE && |grant;
  assign req_byte = i_req_byte[int'(sel)*AW +: AW];
  assign chunk    = AW'(min_bytes(64'(rem), 64'(P_MAX_BURST_BYTE)));
  assign last     = 64'(rem) <= 64'(P_MAX_BURST_BYTE);
  // zero-byte requests complete straight from IDLE without touching the DDR channel
  assign fin      = (acc && req_byte == '0) || (state == WAIT_FIN && i_ddr_rd_finish);
  assign fin_port = state == IDLE ? sel : port;
  assign o_req_ready    = state == IDLE ? grant : '0;
  assign o_ddr_rd_valid = state == ISSUE;
  assign o_ddr_rd_byte  = state == ISSUE ? chunk : '0;
  assign o_ddr_rd_last  = state == ISSUE && last;
  assign o_ddr_rd_queue = state == ISSUE ? queue : '0;
  assign o_ddr_rd_port  = state == ISSUE ? port : '0;
  assign o_port_done    = done;
  // busy extends into the done cycle, where the FSM is already back in IDLE
  assign o_port_busy    = state != IDLE ? N'(1) << port : done;
  assign o_done_cnt     = cnt;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     state_nx = acc && req_byte != '0 ? ISSUE : IDLE;
      ISSUE:    state_nx = i_ddr_rd_ready && last ? WAIT_FIN : ISSUE;
      WAIT_FIN: state_nx = i_ddr_rd_finish ? IDLE : WAIT_FIN;
      default:  state_nx = IDLE;
    endcase
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      port  <= '0;
      queue <= '0;
      rem   <= '0;
      ptr   <= '0;
      done  <= '0;
      cnt   <= '0;
    end else begin
      done <= fin ? N'(1) << fin_port : '0;
      if (acc) begin
        port  <= sel;
        queue <= i_req_queue[int'(sel)*Q +: Q];
        rem   <= req_byte;
      end
      if (state == ISSUE && i_ddr_rd_ready) rem <= rem - chunk;
      if (fin) begin
        ptr <= fin_port == PW'(N - 1) ? '0 : fin_port + 1'b1;
        if (~&cnt[int'(fin_port)*CW +: CW]) cnt[int'(fin_port)*CW +: CW] <= cnt[int'(fin_port)*CW +: CW] + 1'b1;
      end
    end
endmodule

// File: tb/tb_ddr_rd_port_arbiter.sv
// tb_ddr_rd_port_arbiter: randomized checks of round-robin and fixed-priority arbiters against a transaction-level model
module tb_ddr_rd_port_arbiter;
  localparam int MAXB = 4096;
  logic clk = 1'b0, rst_n = 1'b1;
  logic [3:0] valid = '0;
  logic [11:0] qv = '0;
  logic [127:0] bv = '0;
  logic ddr_ready = 1'b0, fin = 1'b0;
  logic [3:0] rdy0, rdy1, done0, done1, busy0, busy1;
  logic v0, v1, l0, l1;
  logic [2:0] q0, q1;
  logic [31:0] b0, b1;
  logic [1:0] p0, p1;
  logic [63:0] c0;
  logic [7:0] c1;
  logic [3:0] ready, done, busy;
  logic cv, cl;
  logic [2:0] cq;
  logic [31:0] cb;
  logic [1:0] cp;
  logic [63:0] cnt_o;
  int mode = 0, ptr = 0, n_cmp = 0, n_bad = 0;
  int cnt [4];
  int req_b [4];
  int req_q [4];
  always #5 clk = ~clk;
  ddr_rd_port_arbiter dut_rr (
    .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(valid), .o_req_ready(rdy0),
    .i_req_queue(qv), .i_req_byte(bv), .o_ddr_rd_valid(v0), .i_ddr_rd_ready(ddr_ready),
    .o_ddr_rd_queue(q0), .o_ddr_rd_byte(b0), .o_ddr_rd_port(p0), .o_ddr_rd_last(l0),
    .i_ddr_rd_finish(fin), .o_port_done(done0), .o_port_busy(busy0), .o_done_cnt(c0)
  );
  ddr_rd_port_arbiter #(.P_ARB_MODE(1), .P_CNT_WIDTH(2)) dut_fx (
    .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(valid), .o_req_ready(rdy1),
    .i_req_queue(qv), .i_req_byte(bv), .o_ddr_rd_valid(v1), .i_ddr_rd_ready(ddr_ready),
    .o_ddr_rd_queue(q1), .o_ddr_rd_byte(b1), .o_ddr_rd_port(p1), .o_ddr_rd_last(l1),
    .i_ddr_rd_finish(fin), .o_port_done(done1), .o_port_busy(busy1), .o_done_cnt(c1)
  );
  assign ready = mode != 0 ? rdy1 : rdy0;
  assign done  = mode != 0 ? done1 : done0;
  assign busy  = mode != 0 ? busy1 : busy0;
  assign cv    = mode != 0 ? v1 : v0;
  assign cl    = mode != 0 ? l1 : l0;
  assign cq    = mode != 0 ? q1 : q0;
  assign cb    = mode != 0 ? b1 : b0;
  assign cp    = mode != 0 ? p1 : p0;
  assign cnt_o = mode != 0 ? 64'(c1) : c0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask
  function automatic int pick(input logic [3:0] v);
    int k;
    for (int i = 0; i < 4; i++) begin
      k = mode != 0 ? i : (ptr + i) % 4;
      if (v[k]) return k;
    end
    return -1;
  endfunction
  function automatic logic [63:0] cnt_exp();
    logic [63:0] r;
    r = '0;
    for (int k = 0; k < 4; k++) r = r | (64'(cnt[k]) << (mode != 0 ? 2 * k : 16 * k));
    return r;
  endfunction
  function automatic void complete(input int p);
    int sat;
    sat = mode != 0 ? 3 : 65535;
    cnt[p] = cnt[p] < sat ? cnt[p] + 1 : sat;
    ptr = (p + 1) % 4;
  endfunction
  task automatic set_req(input int p, input int b, input int q);
    req_b[p] = b;
    req_q[p] = q;
  endtask
  task automatic zero_outputs(input string tag);
    chk({tag, "_ready"}, ready, 0);
    chk({tag, "_valid"}, cv, 0);
    chk({tag, "_byte"}, cb, 0);
    chk({tag, "_last"}, cl, 0);
    chk({tag, "_queue"}, cq, 0);
    chk({tag, "_port"}, cp, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_cnt"}, cnt_o, 0);
  endtask
  task automatic do_reset(input int new_mode);
    @(negedge clk);
    valid = '0;
    fin = 1'b0;
    ddr_ready = 1'b0;
    rst_n = 1'b0;
    mode = new_mode;
    ptr = 0;
    for (int k = 0; k < 4; k++) cnt[k] = 0;
    #1;
    zero_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  task automatic txn(input logic [3:0] vm, input int stall_at, input int stall_len, input bit rnd, input bit rst_wait);
    int p, n, w, eb;
    logic [3:0] oh;
    @(negedge clk);
    valid = vm;
    ddr_ready = 1'b0;
    fin = 1'b0;
    for (int k = 0; k < 4; k++) begin
      bv[32*k +: 32] = 32'(req_b[k]);
      qv[3*k +: 3] = 3'(req_q[k]);
    end
    #1;
    p = pick(vm);
    oh = p < 0 ? 4'b0 : 4'b1 << p;
    chk("accept_ready", ready, oh);
    chk("idle_busy", busy, 0);
    chk("idle_done", done, 0);
    chk("idle_valid", cv, 0);
    if (p < 0) return;
    @(negedge clk);
    if (req_b[p] == 0) begin
      valid = '0;
      #1;
      complete(p);
      chk("zero_done", done, oh);
      chk("zero_busy", busy, oh);
      chk("zero_valid", cv, 0);
      chk("zero_cnt", cnt_o, cnt_exp());
      return;
    end
    n = (req_b[p] + MAXB - 1) / MAXB;
    for (int k = 0; k < n; k++) begin
      eb = k == n - 1 ? req_b[p] - (n - 1) * MAXB : MAXB;
      w = k == stall_at ? stall_len : rnd ? int'($urandom_range(0, 2)) : 0;
      for (int s = 0; s <= w; s++) begin
        ddr_ready = s == w;
        fin = rnd && $urandom_range(0, 3) == 0;
        #1;
        chk("cmd_valid", cv, 1);
        chk("cmd_byte", cb, 64'(eb));
        chk("cmd_last", cl, k == n - 1);
        chk("cmd_port", cp, 64'(p));
        chk("cmd_queue", cq, 64'(req_q[p]));
        chk("cmd_busy", busy, oh);
        chk("cmd_req_ready", ready, 0);
        chk("cmd_done", done, 0);
        @(negedge clk);
      end
    end
    ddr_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
    fin = 1'b0;
    w = rnd ? int'($urandom_range(0, 3)) : 1;
    for (int s = 0; s < w; s++) begin
      #1;
      chk("wait_valid", cv, 0);
      chk("wait_busy", busy, oh);
      chk("wait_req_ready", ready, 0);
      chk("wait_done", done, 0);
      @(negedge clk);
    end
    if (rst_wait) begin
      valid = '0;
      rst_n = 1'b0;
      ptr = 0;
      for (int k = 0; k < 4; k++) cnt[k] = 0;
      #1;
      zero_outputs("midrst");
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("midrst_no_done", done, 0);
      return;
    end
    fin = 1'b1;
    #1;
    chk("fin_cycle_done", done, 0);
    @(negedge clk);
    fin = 1'b0;
    valid = '0;
    #1;
    complete(p);
    chk("done", done, oh);
    chk("done_busy", busy, oh);
    chk("done_cnt", cnt_o, cnt_exp());
    chk("done_valid", cv, 0);
  endtask
  task automatic stray_finish();
    @(negedge clk);
    valid = '0;
    fin = 1'b1;
    @(negedge clk);
    fin = 1'b0;
    #1;
    chk("stray_done", done, 0);
    chk("stray_valid", cv, 0);
    chk("stray_cnt", cnt_o, cnt_exp());
  endtask
  task automatic rand_reqs();
    int b;
    for (int k = 0; k < 4; k++) begin
      case ($urandom_range(0, 7))
        0: b = 0;
        1: b = 1;
        2: b = MAXB - 1;
        3: b = MAXB;
        4: b = MAXB + 1;
        5: b = 2 * MAXB;
        default: b = int'($urandom_range(1, 20000));
      endcase
      set_req(k, b, int'($urandom_range(0, 7)));
    end
  endtask
  initial begin
    for (int k = 0; k < 4; k++) begin
      cnt[k] = 0;
      set_req(k, 0, 0);
    end
    #1;
    rst_n = 1'b0;
    #1;
    zero_outputs("por");
    @(negedge clk);
    rst_n = 1'b1;
    set_req(2, 10000, 5);
    txn(4'b0100, -1, 0, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) set_req(k, 100, k);
    repeat (5) txn(4'b1111, -1, 0, 1'b0, 1'b0);
    set_req(3, 8193, 6);
    txn(4'b1000, 1, 5, 1'b0, 1'b0);
    set_req(0, 0, 1);
    txn(4'b0001, -1, 0, 1'b0, 1'b0);
    stray_finish();
    repeat (40) begin
      rand_reqs();
      txn(4'($urandom_range(0, 15)), -1, 0, 1'b1, 1'b0);
    end
    set_req(1, 5000, 2);
    txn(4'b0010, -1, 0, 1'b0, 1'b1);
    txn(4'b0010, -1, 0, 1'b0, 1'b0);
    do_reset(1);
    set_req(1, 300, 1);
    set_req(3, 400, 3);
    txn(4'b1010, -1, 0, 1'b0, 1'b0);
    txn(4'b1010, -1, 0, 1'b0, 1'b0);
    txn(4'b1000, -1, 0, 1'b0, 1'b0);
    set_req(0, 0, 4);
    repeat (5) txn(4'b0001, -1, 0, 1'b0, 1'b0);
    repeat (40) begin
      rand_reqs();
      txn(4'($urandom_range(0, 15)), -1, 0, 1'b1, 1'b0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ddr_rd_port_arbiter.md
Name: ddr_rd_port_arbiter

Overview:
N-port successor to the two-port DDR read controller. Per-port read requests (queue, byte count) from uplink read controllers enter on valid/ready. A round-robin or fixed-priority arbiter selects one port at a time. The granted request is split into bursts of at most P_MAX_BURST_BYTE and issued on a single DDR read command channel. The arbiter waits for the DDR completion, then pulses a per-port done and keeps saturating per-port completion counters.

Parameters:
P_PORT_NUM, 4, number of requesting ports (>=2)
C_M_AXI_ADDR_WIDTH, 32, byte-count width
P_DDR_LOCAL_QUEUE, 3, queue-id width
P_MAX_BURST_BYTE, 4096, max bytes per DDR command (power of two, < 2^C_M_AXI_ADDR_WIDTH)
P_ARB_MODE, 0, 0 = round-robin, 1 = fixed priority (port 0 highest)
P_CNT_WIDTH, 16, per-port completion counter width

Ports:
i_clk  in  1  clock
i_rst_n  in  1  asynchronous active-low reset
i_req_valid  in  P_PORT_NUM  per-port request valid
o_req_ready  out  P_PORT_NUM  per-port request accept
i_req_queue  in  P_PORT_NUM*P_DDR_LOCAL_QUEUE  flattened queue ids, port k at [k*Q +: Q]
i_req_byte  in  P_PORT_NUM*C_M_AXI_ADDR_WIDTH  flattened byte counts
o_ddr_rd_valid  out  1  DDR command valid
i_ddr_rd_ready  in  1  DDR command accept
o_ddr_rd_queue  out  P_DDR_LOCAL_QUEUE  queue of current command
o_ddr_rd_byte  out  C_M_AXI_ADDR_WIDTH  bytes of current chunk
o_ddr_rd_port  out  $clog2(P_PORT_NUM)  granted port index
o_ddr_rd_last  out  1  current chunk is the final chunk of the request
i_ddr_rd_finish  in  1  one-cycle pulse: final chunk data fully returned
o_port_done  out  P_PORT_NUM  one-cycle done pulse to the granted port
o_port_busy  out  P_PORT_NUM  one-hot of the granted port while not IDLE
o_done_cnt  out  P_PORT_NUM*P_CNT_WIDTH  saturating completed-request counters

Behaviour:
- Reset: all outputs 0. State is IDLE. RR pointer is 0. Counters are 0. Reset mid-operation drops the in-flight request silently, with no done pulse.
- FSM states: IDLE, ISSUE, WAIT_FIN.
- IDLE:
  - o_req_ready is combinational and one-hot for the arbitration winner among i_req_valid; it is 0 in all other states.
  - RR mode: search starts at the RR pointer and wraps modulo P_PORT_NUM.
  - Fixed mode: lowest valid index wins.
  - On handshake in cycle T: latch port, queue and byte count into rem. Go to ISSUE, with o_ddr_rd_valid high at T+1.
  - Zero-byte request: accept it, pulse o_port_done at T+1, increment the counter, stay IDLE. No DDR command is issued.
- ISSUE:
  - o_ddr_rd_byte = min(rem, P_MAX_BURST_BYTE).
  - o_ddr_rd_last = (rem <= P_MAX_BURST_BYTE).
  - o_ddr_rd_queue and o_ddr_rd_port hold the latched values.
  - All command fields stay stable while valid && !ready.
  - On valid && ready: rem -= chunk. If last, deassert valid and go to WAIT_FIN. Otherwise stay in ISSUE and present the next chunk in the next cycle (back-to-back allowed).
- WAIT_FIN:
  - On i_ddr_rd_finish: pulse o_port_done[port] for one cycle in the next cycle, increment o_done_cnt[port] (saturates at all-ones), go to IDLE.
  - RR pointer becomes port+1, modulo P_PORT_NUM.
  - i_ddr_rd_finish in any other state is ignored.
- o_port_busy[port] is high from the cycle after acceptance through the cycle that contains the done pulse.
- The minimum gap between acceptances is 3 cycles (T accept, ISSUE, WAIT_FIN, IDLE). No request is accepted while not IDLE.
- The RR pointer updates only on completion, and on zero-byte completion. Fixed mode ignores the pointer.

Decomposition:
- Shared package holds:
  - FSM state encoding (2 bits)
  - function clog2
  - function min_bytes
  - function rr_pick (request vector, pointer -> one-hot)
- One sub-module, ddr_rd_rr_arb: combinational round-robin/priority one-hot pick, parametrised on P_PORT_NUM and P_ARB_MODE.
- The top module holds the FSM, the chunk splitter and the counters.

Test Plan:
- Single request, port 2: byte=10000, P_MAX_BURST_BYTE=4096, ready always 1 -> three commands (4096, 4096, 1808) on consecutive cycles, last=1 on the third, port=2. Finish -> o_port_done=4'b0100 once and cnt[2]=1.
- RR fairness: all 4 ports valid continuously with byte=100 -> grants in order 0,1,2,3,0, each done before the next accept.
- Fixed priority (P_ARB_MODE=1): ports 1 and 3 valid -> port 1 served first. Port 1 re-requests before port 3 is served -> port 1 wins again.
- Backpressure: i_ddr_rd_ready held low 5 cycles during chunk 2 of byte=8193 -> command fields stable. Chunks are 4096, 4096, 1 after release.
- Zero-byte on port 0 -> accepted, no o_ddr_rd_valid, done pulse next cycle. A stray i_ddr_rd_finish while IDLE has no effect.
- Reset asserted while in WAIT_FIN with port 1 busy -> all outputs 0 immediately, no done pulse. After release, a new request on port 1 is accepted normally.
